subps_arbiter: RTL

- Owns the 1-bit SubPS branch-flag store used by the join datapath's B stage.
- Shares the store between two requesters:
  - Lookup port: driven by the stage, 4-phase Send/Ack, 7-bit destination in, MF out.
  - Write port: host/loader, 4-phase Send/Ack, programs entries.
- Sequences a power-up clear of the whole store; requests are held off until the clear completes.

---
 rtl/subps_arbiter_if.sv | 31 +++
 rtl/subps_arbiter.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/subps_arbiter_if.sv
// SubPS arbiter handshake bundle: lookup port (Send/Ack, DEST in, MF/ERR out)
// and write port (Send/Ack, ADDR/DATA in), plus the INIT_DONE status flag.
interface subps_arbiter_if #(
  parameter int ADDR_W = 6,
  parameter int DEST_W = 7
);
  logic              LK_Send_in;
  logic [DEST_W-1:0] LK_DEST;
  logic              LK_Ack_out;
  logic              LK_MF;
  logic              LK_ERR;
  logic              WR_Send_in;
  logic [ADDR_W-1:0] WR_ADDR;
  logic              WR_DATA;
  logic              WR_Ack_out;
  logic              INIT_DONE;

  modport master (
    output LK_Send_in, LK_DEST,
    output WR_Send_in, WR_ADDR, WR_DATA,
    input  LK_Ack_out, LK_MF, LK_ERR,
    input  WR_Ack_out, INIT_DONE
  );

  modport slave (
    input  LK_Send_in, LK_DEST,
    input  WR_Send_in, WR_ADDR, WR_DATA,
    output LK_Ack_out, LK_MF, LK_ERR,
    output WR_Ack_out, INIT_DONE
  );
endinterface

// File: rtl/subps_arbiter.sv
// SubPS flag store shared by a lookup port and a write port (4-phase each),
// round-robin on collisions, power-up clear. Ports: CP, MR_N, bus (slave).
// SUBPS_PRELOAD_EN: clear writes a fixed preload pattern instead of zeros.
module subps_arbiter #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6,
  parameter int DEST_W = 7
) (
  input  logic          CP,
  input  logic          MR_N,
  subps_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_CLEAR,
    S_READY,
    S_LK_ACK,
    S_WR_ACK
  } state_e;

  localparam logic [DEST_W:0]   DEPTH_X  = (DEST_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(DEPTH-1);

`ifdef SUBPS_PRELOAD_EN
  // entries 1,2,3,4,7,13,16,18 set
  localparam logic [DEPTH-1:0] PRELOAD = DEPTH'(64'h5_209E);
`endif

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              rr_q, rr_d;
  logic              lk_ack_q, lk_ack_d;
  logic              mf_q, mf_d;
  logic              err_q, err_d;
  logic              wr_ack_q, wr_ack_d;
  logic              done_q, done_d;

  logic [DEPTH-1:0]  mem_q;
  logic              we;
  logic [ADDR_W-1:0] wa;
  logic              wd;

  logic              lk, wr;
  logic              grant_lk, grant_wr;
  logic              lk_oor;
  logic              rd;
  logic              clr_val;

  assign lk = bus.LK_Send_in;
  assign wr = bus.WR_Send_in;

  // rr_q: 0 favours lookup, 1 favours write
  assign grant_lk = lk & (~wr | ~rr_q);
  assign grant_wr = wr & (~lk |  rr_q);

  assign lk_oor = {1'b0, bus.LK_DEST} >= DEPTH_X;
  assign rd     = mem_q[bus.LK_DEST[ADDR_W-1:0]];

`ifdef SUBPS_PRELOAD_EN
  assign clr_val = PRELOAD[cnt_q];
`else
  assign clr_val = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rr_d     = rr_q;
    lk_ack_d = lk_ack_q;
    mf_d     = mf_q;
    err_d    = err_q;
    wr_ack_d = wr_ack_q;
    done_d   = done_q;
    we       = 1'b0;
    wa       = cnt_q;
    wd       = 1'b0;
    unique case (state_q)
      S_CLEAR: begin
        we    = 1'b1;
        wa    = cnt_q;
        wd    = clr_val;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = S_READY;
          done_d  = 1'b1;
        end
      end
      S_READY: begin
        unique case (1'b1)
          grant_lk: begin
            lk_ack_d = 1'b1;
            err_d    = lk_oor;
            mf_d     = lk_oor ? 1'b0 : rd;
            state_d  = S_LK_ACK;
          end
          grant_wr: begin
            we       = 1'b1;
            wa       = bus.WR_ADDR;
            wd       = bus.WR_DATA;
            wr_ack_d = 1'b1;
            state_d  = S_WR_ACK;
          end
          default: ;
        endcase
        if (lk & wr) rr_d = ~rr_q;
      end
      S_LK_ACK: begin
        if (!lk) begin
          lk_ack_d = 1'b0;
          mf_d     = 1'b0;
          err_d    = 1'b0;
          state_d  = S_READY;
        end
      end
      S_WR_ACK: begin
        if (!wr) begin
          wr_ack_d = 1'b0;
          state_d  = S_READY;
        end
      end
      default: state_d = S_CLEAR;
    endcase
  end

  always_ff @(posedge CP or negedge MR_N) begin
    if (!MR_N) begin
      state_q  <= S_CLEAR;
      cnt_q    <= '0;
      rr_q     <= 1'b0;
      lk_ack_q <= 1'b0;
      mf_q     <= 1'b0;
      err_q    <= 1'b0;
      wr_ack_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rr_q     <= rr_d;
      lk_ack_q <= lk_ack_d;
      mf_q     <= mf_d;
      err_q    <= err_d;
      wr_ack_q <= wr_ack_d;
      done_q   <= done_d;
    end
  end

  // store contents are defined by the clear sweep, not by reset
  always_ff @(posedge CP) begin
    if (we) mem_q[wa] <= wd;
  end

  assign bus.LK_Ack_out = lk_ack_q;
  assign bus.LK_MF      = mf_q;
  assign bus.LK_ERR     = err_q;
  assign bus.WR_Ack_out = wr_ack_q;
  assign bus.INIT_DONE  = done_q;

endmodule
